// File: rtl/bcalc_pkg.sv
// Shared constants for the binary calculator engine: ALU opcodes, command
// modes, FSM state encoding, flag bit positions and the frame width helper.
// Optional feature macro used by this slice: BCALC_PARITY_EN.
package bcalc_pkg;

    // ALU opcodes (codes C..F are undefined and yield Result=0, Flags=Z)
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_ROL  = 4'h9;
    localparam logic [3:0] OP_ROR  = 4'hA;
    localparam logic [3:0] OP_PASS = 4'hB;

    // Command modes
    localparam logic [1:0] MODE_TX    = 2'd0;
    localparam logic [1:0] MODE_STORE = 2'd1;
    localparam logic [1:0] MODE_LOAD  = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EXEC  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_STORE = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    // Flag nibble bit positions
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // Frame = {Flags[3:0], Sel[3:0], Result, InB, InA}
    function automatic int frame_w(input int w);
        return 3 * w + 8;
    endfunction

endpackage

// File: rtl/bcalc_serializer.sv
// LSB-first serial transmitter with programmable bit clock. Each bit lasts
// 2*(div+1) clocks, clk_tx high for the first half. With BCALC_PARITY_EN
// defined an even-parity bit is appended after the frame.
module bcalc_serializer
#(
    parameter int FW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [FW-1:0] frame,
    input  logic [15:0]   div,
    output logic          busy,
    output logic          done,
    output logic          clk_tx,
    output logic          dout_valid,
    output logic          data_out
);

`ifdef BCALC_PARITY_EN
    localparam int NB = FW + 1;
`else
    localparam int NB = FW;
`endif
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST_BIT = CW'(NB - 1);

    // Even parity: the returned bit makes the total number of ones even
    function automatic logic even_parity(input logic [FW-1:0] v);
        return ^v;
    endfunction

    logic [NB-1:0] shreg_q, shreg_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [16:0]   cnt_q, cnt_d;
    logic          start_q, start_d;
    logic          active_q, active_d;
    logic          clk_tx_q, clk_tx_d;
    logic          dout_valid_q, dout_valid_d;
    logic          data_out_q, data_out_d;
    logic          done_q, done_d;
    logic [16:0]   half_end_s;
    logic [16:0]   bit_end_s;

    assign half_end_s = {1'b0, div};
    assign bit_end_s  = {div, 1'b1};

    // Next-state logic: load, first-bit launch, half-period and bit-period steps
    always_comb begin
        shreg_d      = shreg_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        start_d      = 1'b0;
        active_d     = active_q;
        clk_tx_d     = clk_tx_q;
        dout_valid_d = dout_valid_q;
        data_out_d   = data_out_q;
        done_d       = 1'b0;
        if (load) begin
`ifdef BCALC_PARITY_EN
            shreg_d = {even_parity(frame), frame};
`else
            shreg_d = frame;
`endif
            start_d      = 1'b1;
            active_d     = 1'b1;
            bit_d        = '0;
            cnt_d        = 17'd0;
            clk_tx_d     = 1'b0;
            dout_valid_d = 1'b0;
            data_out_d   = 1'b0;
        end else if (start_q) begin
            clk_tx_d     = 1'b1;
            dout_valid_d = 1'b1;
            data_out_d   = shreg_q[0];
            cnt_d        = 17'd0;
        end else if (active_q) begin
            if (cnt_q == half_end_s) begin
                clk_tx_d = 1'b0;
                cnt_d    = cnt_q + 17'd1;
            end else if (cnt_q == bit_end_s) begin
                cnt_d = 17'd0;
                if (bit_q == LAST_BIT) begin
                    active_d     = 1'b0;
                    clk_tx_d     = 1'b0;
                    dout_valid_d = 1'b0;
                    data_out_d   = 1'b0;
                    done_d       = 1'b1;
                end else begin
                    bit_d      = bit_q + {{(CW-1){1'b0}}, 1'b1};
                    shreg_d    = shreg_q >> 1;
                    data_out_d = shreg_q[1];
                    clk_tx_d   = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 17'd1;
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg_q      <= '0;
            bit_q        <= '0;
            cnt_q        <= 17'd0;
            start_q      <= 1'b0;
            active_q     <= 1'b0;
            clk_tx_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            data_out_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            active_q     <= active_d;
            clk_tx_q     <= clk_tx_d;
            dout_valid_q <= dout_valid_d;
            data_out_q   <= data_out_d;
            done_q       <= done_d;
        end
    end

    assign busy       = active_q;
    assign done       = done_q;
    assign clk_tx     = clk_tx_q;
    assign dout_valid = dout_valid_q;
    assign data_out   = data_out_q;

endmodule

// File: rtl/bcalc_engine.sv
// Binary calculator engine: command handshake, registered ALU, DEPTH-entry
// frame store and serial transmitter. Optional macro: BCALC_PARITY_EN
// (handled inside bcalc_serializer).
module bcalc_engine
    import bcalc_pkg::*;
#(
    parameter  int W           = 8,
    parameter  int DEPTH       = 16,
    parameter  int DEFAULT_DIV = 1,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CmdValid,
    output logic          CmdReady,
    input  logic [1:0]    CmdMode,
    input  logic [AW-1:0] CmdAddr,
    input  logic [3:0]    Sel,
    input  logic [W-1:0]  InA,
    input  logic [W-1:0]  InB,
    input  logic          CfgValid,
    input  logic [15:0]   CfgDiv,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic          DoutValid,
    output logic          DataOut,
    output logic          ClkTx
);

    localparam int FW   = frame_w(W);
    localparam int AMAX = 1 << AW;
    // One bit per addressable slot: set where the address lies inside DEPTH
    localparam logic [AMAX-1:0] RANGE_MASK = {AMAX{1'b1}} >> (AMAX - DEPTH);

    logic [2:0]      state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]      sel_q, sel_d, flags_q, flags_d;
    logic [1:0]      mode_q, mode_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     div_q, div_d;
    logic [AMAX-1:0] valid_q, valid_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [FW-1:0]   mem_q [AMAX];

    logic [W-1:0]    alu_res_s;
    logic            alu_c_s, alu_v_s;
    logic [3:0]      alu_flags_s;
    logic [FW-1:0]   frame_s;
    logic [FW-1:0]   ser_frame_s;
    logic            ser_load_s, ser_busy_s, ser_done_s;
    logic            mem_we_s, addr_ok_s;

    assign frame_s   = {flags_q, sel_q, res_q, b_q, a_q};
    assign addr_ok_s = RANGE_MASK[addr_q];

    // ALU on the command-port operands; the result is captured at accept
    always_comb begin
        alu_res_s   = '0;
        alu_c_s     = 1'b0;
        alu_v_s     = 1'b0;
        alu_flags_s = 4'b0000;
        case (Sel)
            OP_ADD: begin
                {alu_c_s, alu_res_s} = {1'b0, InA} + {1'b0, InB};
                alu_v_s = (InA[W-1] == InB[W-1]) && (alu_res_s[W-1] != InA[W-1]);
            end
            OP_SUB: begin
                {alu_c_s, alu_res_s} = {1'b0, InA} - {1'b0, InB};
                alu_v_s = (InA[W-1] != InB[W-1]) && (alu_res_s[W-1] != InA[W-1]);
            end
            OP_MUL:  alu_res_s = InA * InB;
            OP_AND:  alu_res_s = InA & InB;
            OP_OR:   alu_res_s = InA | InB;
            OP_XOR:  alu_res_s = InA ^ InB;
            OP_NOT:  alu_res_s = ~InA;
            OP_SHL: begin
                alu_res_s = {InA[W-2:0], 1'b0};
                alu_c_s   = InA[W-1];
            end
            OP_SHR: begin
                alu_res_s = {1'b0, InA[W-1:1]};
                alu_c_s   = InA[0];
            end
            OP_ROL:  alu_res_s = {InA[W-2:0], InA[W-1]};
            OP_ROR:  alu_res_s = {InA[0], InA[W-1:1]};
            OP_PASS: alu_res_s = InA;
            default: alu_res_s = '0;
        endcase
        if (Sel > OP_PASS) begin
            alu_flags_s = 4'b0001;
        end else begin
            alu_flags_s[FLAG_Z] = (alu_res_s == '0);
            alu_flags_s[FLAG_C] = alu_c_s;
            alu_flags_s[FLAG_N] = alu_res_s[W-1];
            alu_flags_s[FLAG_V] = alu_v_s;
        end
    end

    // Command FSM, config capture and store bookkeeping
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        sel_d       = sel_q;
        flags_d     = flags_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        div_d       = div_q;
        valid_d     = valid_q;
        mem_we_s    = 1'b0;
        ser_load_s  = 1'b0;
        ser_frame_s = frame_s;
        case (state_q)
            ST_IDLE: begin
                if (CfgValid) begin
                    div_d = CfgDiv;
                end else begin
                    div_d = div_q;
                end
                if (CmdValid) begin
                    a_d     = InA;
                    b_d     = InB;
                    sel_d   = Sel;
                    res_d   = alu_res_s;
                    flags_d = alu_flags_s;
                    mode_d  = CmdMode;
                    addr_d  = CmdAddr;
                    case (CmdMode)
                        MODE_TX, MODE_STORE: state_d = ST_EXEC;
                        MODE_LOAD:           state_d = ST_LOAD;
                        default:             state_d = ST_ERR;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (mode_q == MODE_TX) begin
                    ser_load_s = 1'b1;
                    state_d    = ST_SHIFT;
                end else if (addr_ok_s) begin
                    state_d = ST_STORE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_STORE: begin
                mem_we_s        = 1'b1;
                valid_d[addr_q] = 1'b1;
                state_d         = ST_DONE;
            end
            ST_LOAD: begin
                if (addr_ok_s && valid_q[addr_q]) begin
                    ser_frame_s = mem_q[addr_q];
                    ser_load_s  = 1'b1;
                    state_d     = ST_SHIFT;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_SHIFT: begin
                if (ser_done_s && !ser_busy_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE) || (state_d == ST_ERR);
        err_d       = (state_d == ST_ERR);
    end

    // Control and datapath registers; reset aborts any command in flight
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sel_q       <= 4'h0;
            flags_q     <= 4'h0;
            mode_q      <= MODE_TX;
            addr_q      <= '0;
            div_q       <= 16'(DEFAULT_DIV);
            valid_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            sel_q       <= sel_d;
            flags_q     <= flags_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            div_q       <= div_d;
            valid_q     <= valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Frame store array; contents are qualified by valid_q, so no reset
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= frame_s;
        end
    end

    bcalc_serializer #(
        .FW (FW)
    ) u_ser (
        .clk        (Clk),
        .reset_n    (Reset),
        .load       (ser_load_s),
        .frame      (ser_frame_s),
        .div        (div_q),
        .busy       (ser_busy_s),
        .done       (ser_done_s),
        .clk_tx     (ClkTx),
        .dout_valid (DoutValid),
        .data_out   (DataOut)
    );

    assign CmdReady = cmd_ready_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_bcalc_engine.sv
// Self-checking bench for bcalc_engine (W=8, DEPTH=16, DEFAULT_DIV=1).
// Honours BCALC_PARITY_EN to expect the trailing even-parity bit.
module tb_bcalc_engine;

    logic        Clk, Reset, CmdValid, CmdReady, CfgValid;
    logic [1:0]  CmdMode;
    logic [3:0]  CmdAddr, Sel;
    logic [7:0]  InA, InB;
    logic [15:0] CfgDiv;
    logic        Busy, Done, Err, DoutValid, DataOut, ClkTx;

    int tests = 0;
    int fails = 0;
    int cur_div = 1;
    logic [31:0] store_m [16];
    bit          svalid_m [16];

`ifdef BCALC_PARITY_EN
    localparam int NB = 33;
`else
    localparam int NB = 32;
`endif

    bcalc_engine #(.W(8), .DEPTH(16), .DEFAULT_DIV(1)) dut (
        .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdMode(CmdMode), .CmdAddr(CmdAddr), .Sel(Sel), .InA(InA), .InB(InB),
        .CfgValid(CfgValid), .CfgDiv(CfgDiv), .Busy(Busy), .Done(Done), .Err(Err),
        .DoutValid(DoutValid), .DataOut(DataOut), .ClkTx(ClkTx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: frame built from the arithmetic meaning of each opcode
    function automatic logic [31:0] model_frame(input int sel, input int a, input int b);
        int r, sa, sb, sr, res;
        bit c, v;
        c = 0; v = 0; r = 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (sel)
            0: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            1: begin r = a - b; c = (a < b);   sr = sa - sb; v = (sr > 127) || (sr < -128); end
            2: r = a * b;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = ~a;
            7: begin r = a * 2; c = (a >= 128); end
            8: begin r = a / 2; c = (a % 2 == 1); end
            9: r = a * 2 + a / 128;
            10: r = a / 2 + (a % 2) * 128;
            11: r = a;
            default: return {4'b0001, 4'(sel), 8'h00, 8'(b), 8'(a)};
        endcase
        res = r & 255;
        return {v, (res >= 128), c, (res == 0), 4'(sel), 8'(res), 8'(b), 8'(a)};
    endfunction

    function automatic logic [63:0] wire_bits(input logic [31:0] f);
`ifdef BCALC_PARITY_EN
        logic [63:0] w;
        w = {32'h0, f};
        w[32] = ($countones(f) % 2 == 1);
        return w;
`else
        return {32'h0, f};
`endif
    endfunction

    // Offer one command at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [1:0] mode, input logic [3:0] addr, input logic [3:0] sel,
                        input logic [7:0] a, input logic [7:0] b, input bit cfg, input logic [15:0] div);
        chk("ready_before_cmd", CmdReady, 1'b1);
        CmdValid = 1'b1; CmdMode = mode; CmdAddr = addr; Sel = sel; InA = a; InB = b;
        CfgValid = cfg; CfgDiv = div;
        @(negedge Clk);
        CmdValid = 1'b0; CfgValid = 1'b0;
        if (cfg) cur_div = int'(div);
    endtask

    // Capture a transmission and its Done pulse; optionally poke CmdValid mid-frame
    task automatic rx_check(input logic [31:0] frame, input string tag, input bit inject);
        int k, dv, nb, g;
        logic prev;
        logic [63:0] rx;
        k = 1;
        while (!DoutValid && k < 20) begin @(negedge Clk); k++; end
        chk({tag, "_latency"}, k, 3);
        dv = 0; nb = 0; prev = 1'b0; rx = '0; g = 0;
        while (DoutValid && g < 5000) begin
            dv++;
            if (ClkTx && !prev && nb < 64) begin rx[nb] = DataOut; nb++; end
            prev = ClkTx;
            if (inject && dv == 5) begin
                CmdValid = 1'b1; CmdMode = 2'd1; CmdAddr = 4'd7; Sel = 4'd0; InA = 8'h11; InB = 8'h22;
            end
            if (inject && dv == 9) begin
                chk({tag, "_ready_in_shift"}, CmdReady, 1'b0);
                CmdValid = 1'b0;
            end
            @(negedge Clk); g++;
        end
        chk({tag, "_bits"}, nb, NB);
        chk({tag, "_dv_cycles"}, dv, NB * 2 * (cur_div + 1));
        chk({tag, "_data"}, rx, wire_bits(frame));
        g = 0;
        while (!Done && g < 10) begin @(negedge Clk); g++; end
        chk({tag, "_done"}, Done, 1'b1);
        chk({tag, "_err"}, Err, 1'b0);
        @(negedge Clk);
        chk({tag, "_done_pulse"}, Done, 1'b0);
        chk({tag, "_ready_after"}, CmdReady, 1'b1);
    endtask

    // Commands with no transmission: Done (and Err) expected on cycle exp_k after accept
    task automatic wait_end(input bit exp_err, input int exp_k, input string tag);
        int k;
        bit any_dv;
        k = 1; any_dv = 0;
        while (!Done && k < 10) begin
            if (DoutValid) any_dv = 1;
            @(negedge Clk); k++;
        end
        chk({tag, "_done_cycle"}, k, exp_k);
        chk({tag, "_err"}, Err, exp_err);
        chk({tag, "_no_dout"}, any_dv, 1'b0);
        @(negedge Clk);
        chk({tag, "_done_pulse"}, Done, 1'b0);
        chk({tag, "_ready_after"}, CmdReady, 1'b1);
    endtask

    initial begin
        int rises, g;
        logic [1:0] m;
        logic [3:0] ad, sl;
        logic [7:0] ra, rb;
        logic [31:0] f;
        bit cf;
        logic [15:0] dv16;

        Reset = 1'b0; CmdValid = 1'b0; CmdMode = 2'd0; CmdAddr = 4'd0; Sel = 4'd0;
        InA = 8'h00; InB = 8'h00; CfgValid = 1'b0; CfgDiv = 16'd0;
        for (int i = 0; i < 16; i++) svalid_m[i] = 0;

        // 1. reset held 3 cycles, then released
        repeat (3) @(posedge Clk);
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk);
        chk("rst_cmdready", CmdReady, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_doutvalid", DoutValid, 1'b0);
        chk("rst_dataout", DataOut, 1'b0);
        chk("rst_clktx", ClkTx, 1'b0);

        // 2. compute+transmit F0 + 20
        send(2'd0, 4'd0, 4'd0, 8'hF0, 8'h20, 1'b0, 16'd0);
        rx_check(32'h2010_20F0, "tx_add", 1'b0);

        // 3. compute+store then load+transmit
        send(2'd1, 4'd5, 4'd1, 8'h05, 8'h07, 1'b0, 16'd0);
        store_m[5] = 32'h61FE_0705; svalid_m[5] = 1;
        wait_end(1'b0, 3, "store5");
        send(2'd2, 4'd5, 4'd0, 8'h00, 8'h00, 1'b0, 16'd0);
        rx_check(32'h61FE_0705, "load5", 1'b0);

        // 4. loads of empty entries; address 20 wraps to 4 on the 4-bit port
        send(2'd2, 4'd3, 4'd0, 8'h00, 8'h00, 1'b0, 16'd0);
        wait_end(1'b1, 2, "load_empty3");
        send(2'd2, 4'(20), 4'd0, 8'h00, 8'h00, 1'b0, 16'd0);
        wait_end(1'b1, 2, "load_addr20");
        send(2'd3, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0, 16'd0);
        wait_end(1'b1, 1, "mode3");

        // 5. reset at bit 10 of a transmit
        send(2'd0, 4'd0, 4'd5, 8'h5A, 8'h3C, 1'b0, 16'd0);
        rises = 0; g = 0;
        while (rises < 11 && g < 1000) begin
            @(negedge Clk); g++;
            if (ClkTx && DoutValid) begin
                rises++;
                while (ClkTx && g < 1000) begin @(negedge Clk); g++; end
            end
        end
        chk("bit10_reached", rises, 11);
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_doutvalid", DoutValid, 1'b0);
        chk("abort_clktx", ClkTx, 1'b0);
        chk("abort_busy", Busy, 1'b0);
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk);
        cur_div = 1;
        for (int i = 0; i < 16; i++) svalid_m[i] = 0;
        send(2'd2, 4'd5, 4'd0, 8'h00, 8'h00, 1'b0, 16'd0);
        wait_end(1'b1, 2, "load5_after_reset");

        // 6. commands offered during SHIFT are dropped
        send(2'd0, 4'd0, 4'd2, 8'h13, 8'h0B, 1'b0, 16'd0);
        rx_check(model_frame(2, 8'h13, 8'h0B), "tx_inject", 1'b1);
        send(2'd2, 4'd7, 4'd0, 8'h00, 8'h00, 1'b0, 16'd0);
        wait_end(1'b1, 2, "load7_not_written");

        // config applied together with an accepted command
        send(2'd0, 4'd0, 4'd11, 8'h80, 8'h01, 1'b1, 16'd0);
        rx_check(model_frame(11, 8'h80, 8'h01), "tx_cfg_div0", 1'b0);

        // randomized commands against the reference model
        for (int i = 0; i < 24; i++) begin
            m  = 2'($urandom_range(0, 3));
            ad = 4'($urandom_range(0, 15));
            sl = 4'($urandom_range(0, 15));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            cf = ($urandom_range(0, 3) == 0);
            dv16 = 16'($urandom_range(0, 2));
            f = model_frame(int'(sl), int'(ra), int'(rb));
            send(m, ad, sl, ra, rb, cf, dv16);
            case (m)
                2'd0: rx_check(f, "rnd_tx", 1'b0);
                2'd1: begin
                    store_m[ad] = f; svalid_m[ad] = 1;
                    wait_end(1'b0, 3, "rnd_store");
                end
                2'd2: begin
                    if (svalid_m[ad]) rx_check(store_m[ad], "rnd_load", 1'b0);
                    else wait_end(1'b1, 2, "rnd_load_empty");
                end
                default: wait_end(1'b1, 1, "rnd_mode3");
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
